byte_stream_packer: RTL and testbench

- Parametrised successor of the team's byte aligner.
- Accepts variable-length byte chunks (0..IN_BYTES valid bytes per beat) on a valid/ready input and packs them densely into fixed OUT_BYTES-wide words on a valid/ready output.
- Adds over the previous generation:
  - independent input and output widths;
  - backpressure on both sides;
  - masking of unused input bytes;
  - a flush that emits a zero-padded partial last word.
- Sits between the compressor's variable-length encoder and the fixed-width output FIFO/AXI writer.

---
 rtl/byte_packer_pkg.sv | 37 +++
 rtl/byte_merge_shifter.sv | 54 +++++
 rtl/byte_stream_packer.sv | 176 +++++++++++++++++
 tb/tb_byte_stream_packer.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/byte_packer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : byte_packer_pkg                                                 |
// | Brief  : Shared types and helpers for the byte stream packer: the drain  |
// |          state enum, buffer capacity / occupancy-width helpers and the   |
// |          per-byte masking function used before merging input chunks.     |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
package byte_packer_pkg;

    // RUN: normal packing. FLUSH: draining buffered bytes, input blocked.
    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    // The buffer must hold one full output word plus one maximal input beat,
    // so that a beat can always be appended after a pop.
    function automatic int unsigned cap_bytes(input int unsigned in_bytes,
                                              input int unsigned out_bytes);
        return in_bytes + out_bytes;
    endfunction

    // Width needed to hold an occupancy of 0..cap inclusive.
    function automatic int unsigned cnt_width(input int unsigned cap);
        return $clog2(cap + 1);
    endfunction

    // Byte at position idx of a chunk survives only if it lies below len.
    function automatic logic [7:0] mask_byte(input logic [7:0]  data,
                                             input int unsigned idx,
                                             input int unsigned len);
        return (idx < len) ? data : 8'h00;
    endfunction

endpackage
`default_nettype wire

// File: rtl/byte_merge_shifter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : byte_merge_shifter                                              |
// | Brief  : Combinational datapath of the byte stream packer. Optionally    |
// |          shifts the buffer down by one output word, masks the unused     |
// |          bytes of the incoming chunk and ORs it in at the post-pop       |
// |          occupancy.                                                      |
// | Ports  : cur_buf  - current buffer contents, byte 0 oldest              |
// |          pop      - drop the lowest OUT_BYTES bytes                      |
// |          base     - occupancy after the pop (append position)            |
// |          accept   - merge the incoming chunk                             |
// |          in_data  - incoming chunk, byte 0 in bits 7:0                   |
// |          len      - clamped number of valid chunk bytes                  |
// |          nxt_buf  - buffer contents for the next cycle                   |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module byte_merge_shifter
    import byte_packer_pkg::*;
#(
    parameter int IN_BYTES  = 34,
    parameter int OUT_BYTES = 32,
    parameter int LEN_WIDTH = 8,
    parameter int CNT_WIDTH = 7
) (
    input  logic [(IN_BYTES+OUT_BYTES)*8-1:0] cur_buf,
    input  logic                              pop,
    input  logic [CNT_WIDTH-1:0]              base,
    input  logic                              accept,
    input  logic [IN_BYTES*8-1:0]             in_data,
    input  logic [LEN_WIDTH-1:0]              len,
    output logic [(IN_BYTES+OUT_BYTES)*8-1:0] nxt_buf
);

    localparam int CAP = int'(cap_bytes(IN_BYTES, OUT_BYTES));

    logic [IN_BYTES*8-1:0] w_masked;
    logic [CAP*8-1:0]      w_shifted;
    logic [CAP*8-1:0]      w_placed;

    // Masking keeps the buffer zero above the occupancy, which is what makes
    // the OR-merge safe and gives zero padding on a partial last word.
    for (genvar i = 0; i < IN_BYTES; i++) begin : g_mask
        assign w_masked[i*8 +: 8] = mask_byte(in_data[i*8 +: 8], 32'(i), 32'(len));
    end

    assign w_shifted = pop ? {{(OUT_BYTES*8){1'b0}}, cur_buf[CAP*8-1:OUT_BYTES*8]}
                           : cur_buf;

    assign w_placed  = {{(OUT_BYTES*8){1'b0}}, w_masked} << {base, 3'b000};

    assign nxt_buf   = accept ? (w_shifted | w_placed) : w_shifted;

endmodule
`default_nettype wire

// File: rtl/byte_stream_packer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : byte_stream_packer                                              |
// | Brief  : Packs variable-length byte chunks (0..IN_BYTES per beat) into   |
// |          dense OUT_BYTES-wide words, with backpressure on both sides and |
// |          a flush that drains a zero-padded partial last word.            |
// | Ports  : clk, reset             - clock, synchronous active-high reset   |
// |          in_valid/in_ready      - input handshake                        |
// |          in_data/in_len         - chunk and its valid low-byte count     |
// |          flush_req              - pulse: drain buffered bytes            |
// |          flush_busy/flush_done  - drain in progress / drain finished     |
// |          out_valid/out_ready    - output handshake                       |
// |          out_data/out_bytes     - packed word and its valid byte count   |
// |          out_last               - final word of a drain                  |
// |          stat_in_bytes          - accepted byte counter                  |
// |          stat_out_words         - emitted word counter                   |
// | Config : BYTE_STREAM_PACKER_STATS_EN builds the statistics counters;     |
// |          without it both stat ports read zero.                           |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module byte_stream_packer
    import byte_packer_pkg::*;
#(
    parameter int IN_BYTES  = 34,
    parameter int OUT_BYTES = 32,
    parameter int LEN_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [IN_BYTES*8-1:0]  in_data,
    input  logic [LEN_WIDTH-1:0]   in_len,
    input  logic                   flush_req,
    output logic                   flush_busy,
    output logic                   flush_done,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_BYTES*8-1:0] out_data,
    output logic [LEN_WIDTH-1:0]   out_bytes,
    output logic                   out_last,
    output logic [31:0]            stat_in_bytes,
    output logic [31:0]            stat_out_words
);

    localparam int CAP   = int'(cap_bytes(IN_BYTES, OUT_BYTES));
    localparam int CNT_W = int'(cnt_width(CAP));

    localparam logic [CNT_W-1:0]     c_out_cnt    = CNT_W'(OUT_BYTES);
    localparam logic [LEN_WIDTH-1:0] c_in_len_max = LEN_WIDTH'(IN_BYTES);
    localparam logic [LEN_WIDTH-1:0] c_out_len    = LEN_WIDTH'(OUT_BYTES);

    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [CAP*8-1:0]       r_buf;
    logic                   r_out_valid;
    logic [LEN_WIDTH-1:0]   r_out_bytes;
    logic                   r_out_last;
    logic                   r_flush_busy;
    logic                   r_flush_done;

    logic [LEN_WIDTH-1:0]   w_len;
    logic                   w_pop;
    logic [CNT_W-1:0]       w_dec;
    logic [CNT_W-1:0]       w_base;
    logic                   w_in_ready;
    logic                   w_accept;
    logic [CNT_W-1:0]       w_cnt_n;
    logic                   w_drain_n;
    logic                   w_out_valid_n;
    logic [LEN_WIDTH-1:0]   w_out_bytes_n;
    logic                   w_out_last_n;
    logic [CAP*8-1:0]       w_buf_n;

    always_comb begin
        w_len = (in_len > c_in_len_max) ? c_in_len_max : in_len;
        w_pop = r_out_valid & out_ready;

        // A drain pops a partial word; the buffer still shifts by a full word
        // because everything above the occupancy is zero.
        w_dec = '0;
        if (w_pop) begin
            w_dec = (r_cnt >= c_out_cnt) ? c_out_cnt : r_cnt;
        end
        w_base = r_cnt - w_dec;

        // Room check uses the post-pop occupancy so pop and accept can overlap.
        w_in_ready = (r_state == RUN) && (w_base <= c_out_cnt);
        w_accept   = in_valid & w_in_ready;
        w_cnt_n    = w_base + (w_accept ? CNT_W'(w_len) : '0);

        // Whether next cycle is spent draining; mirrors the state transition.
        w_drain_n = (r_state == RUN) ? flush_req : (r_cnt != '0);

        w_out_valid_n = w_drain_n ? (w_cnt_n != '0) : (w_cnt_n >= c_out_cnt);
        w_out_bytes_n = '0;
        if (w_out_valid_n) begin
            w_out_bytes_n = (w_cnt_n >= c_out_cnt) ? c_out_len : LEN_WIDTH'(w_cnt_n);
        end
        w_out_last_n = w_drain_n && (w_cnt_n != '0) && (w_cnt_n <= c_out_cnt);
    end

    byte_merge_shifter #(
        .IN_BYTES  (IN_BYTES),
        .OUT_BYTES (OUT_BYTES),
        .LEN_WIDTH (LEN_WIDTH),
        .CNT_WIDTH (CNT_W)
    ) u_merge (
        .cur_buf (r_buf),
        .pop     (w_pop),
        .base    (w_base),
        .accept  (w_accept),
        .in_data (in_data),
        .len     (w_len),
        .nxt_buf (w_buf_n)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= RUN;
            r_cnt        <= '0;
            r_buf        <= '0;
            r_out_valid  <= 1'b0;
            r_out_bytes  <= '0;
            r_out_last   <= 1'b0;
            r_flush_busy <= 1'b0;
            r_flush_done <= 1'b0;
        end else begin
            case (r_state)
                RUN:     if (flush_req)     r_state <= FLUSH;
                FLUSH:   if (r_cnt == '0)   r_state <= RUN;
                default:                    r_state <= RUN;
            endcase
            r_cnt        <= w_cnt_n;
            r_buf        <= w_buf_n;
            r_out_valid  <= w_out_valid_n;
            r_out_bytes  <= w_out_bytes_n;
            r_out_last   <= w_out_last_n;
            r_flush_busy <= w_drain_n;
            // Done coincides with the last busy cycle, the one where the
            // drain finds the buffer empty.
            r_flush_done <= w_drain_n && (w_cnt_n == '0);
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = r_out_valid;
    assign out_data   = r_buf[OUT_BYTES*8-1:0];
    assign out_bytes  = r_out_bytes;
    assign out_last   = r_out_last;
    assign flush_busy = r_flush_busy;
    assign flush_done = r_flush_done;

`ifdef BYTE_STREAM_PACKER_STATS_EN
    logic [31:0] r_stat_in;
    logic [31:0] r_stat_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_in  <= '0;
            r_stat_out <= '0;
        end else begin
            if (w_accept) r_stat_in  <= r_stat_in + 32'(w_len);
            if (w_pop)    r_stat_out <= r_stat_out + 32'd1;
        end
    end

    assign stat_in_bytes  = r_stat_in;
    assign stat_out_words = r_stat_out;
`else
    assign stat_in_bytes  = '0;
    assign stat_out_words = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_byte_stream_packer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_byte_stream_packer                                           |
// | Brief  : Self-checking bench for byte_stream_packer. Stimulus pushes the |
// |          hand-computed expected words into a scoreboard queue; an       |
// |          independent monitor pops and compares on every output pop.      |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module tb_byte_stream_packer;

    localparam int IN_BYTES  = 34;
    localparam int OUT_BYTES = 32;
    localparam int LEN_WIDTH = 8;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [IN_BYTES*8-1:0]  in_data = '0;
    logic [LEN_WIDTH-1:0]   in_len = '0;
    logic                   flush_req = 1'b0;
    logic                   flush_busy;
    logic                   flush_done;
    logic                   out_valid;
    logic                   out_ready = 1'b1;
    logic [OUT_BYTES*8-1:0] out_data;
    logic [LEN_WIDTH-1:0]   out_bytes;
    logic                   out_last;
    logic [31:0]            stat_in_bytes;
    logic [31:0]            stat_out_words;

    byte_stream_packer #(
        .IN_BYTES  (IN_BYTES),
        .OUT_BYTES (OUT_BYTES),
        .LEN_WIDTH (LEN_WIDTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .in_len         (in_len),
        .flush_req      (flush_req),
        .flush_busy     (flush_busy),
        .flush_done     (flush_done),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_bytes      (out_bytes),
        .out_last       (out_last),
        .stat_in_bytes  (stat_in_bytes),
        .stat_out_words (stat_out_words)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [OUT_BYTES*8-1:0] data;
        logic [LEN_WIDTH-1:0]   nbytes;
        logic                   last;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned exp_in_bytes = 0;
    int unsigned exp_out_words = 0;

    function automatic logic [IN_BYTES*8-1:0] mk_beat(input int start, input int nvalid);
        logic [IN_BYTES*8-1:0] d;
        for (int i = 0; i < IN_BYTES; i++)
            d[i*8 +: 8] = (i < nvalid) ? 8'((start + i) % 256) : 8'hA5;
        return d;
    endfunction

    function automatic logic [OUT_BYTES*8-1:0] mk_word(input int start, input int n);
        logic [OUT_BYTES*8-1:0] w;
        for (int i = 0; i < OUT_BYTES; i++)
            w[i*8 +: 8] = (i < n) ? 8'((start + i) % 256) : 8'h00;
        return w;
    endfunction

    task automatic push_exp(input logic [OUT_BYTES*8-1:0] d, input int n, input logic last);
        exp_t e;
        e.data   = d;
        e.nbytes = LEN_WIDTH'(n);
        e.last   = last;
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic chk_stats(input string tag);
`ifdef BYTE_STREAM_PACKER_STATS_EN
        chk({tag, "_stat_in"},  64'(stat_in_bytes),  64'(exp_in_bytes));
        chk({tag, "_stat_out"}, 64'(stat_out_words), 64'(exp_out_words));
`else
        chk({tag, "_stat_in"},  64'(stat_in_bytes),  64'(0));
        chk({tag, "_stat_out"}, 64'(stat_out_words), 64'(0));
`endif
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_beat(input logic [IN_BYTES*8-1:0] d, input int len, output int waits);
        in_valid = 1'b1;
        in_data  = d;
        in_len   = LEN_WIDTH'(len);
        waits    = 0;
        @(negedge clk);
        while (!in_ready && waits < 200) begin
            waits++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", waits);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            exp_in_bytes += (len > IN_BYTES) ? IN_BYTES : len;
        end
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d words outstanding, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    // Pulses flush_req, follows the drain to flush_done, then realigns.
    task automatic do_flush(output logic imm_done, output int ready_bad);
        int   n = 0;
        logic seen = 1'b0;
        flush_req = 1'b1;
        @(posedge clk);
        #1;
        flush_req = 1'b0;
        imm_done  = flush_done;
        ready_bad = 0;
        while (!seen && n < 100) begin
            @(negedge clk);
            if (flush_busy && in_ready) ready_bad++;
            if (flush_done) seen = 1'b1;
            n++;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL flush_timeout: flush_done not seen in %0d cycles, required pulse", n);
        end
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: a pop is visible at the negedge before its edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready) begin
                exp_out_words++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word: got data=%h bytes=%0d last=%0b, required no word",
                             out_data, out_bytes, out_last);
                end else begin
                    e = sb.pop_front();
                    if (out_data !== e.data || out_bytes !== e.nbytes || out_last !== e.last) begin
                        errors++;
                        $display("FAIL word: got data=%h bytes=%0d last=%0b required data=%h bytes=%0d last=%0b",
                                 out_data, out_bytes, out_last, e.data, e.nbytes, e.last);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int                     w;
        int                     total_w;
        int                     bad_rdy;
        int                     bad_data;
        logic                   imm;
        logic [IN_BYTES*8-1:0]  d;
        logic [OUT_BYTES*8-1:0] ew;

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        chk("rst_out_valid",  64'(out_valid),  64'(0));
        chk("rst_out_bytes",  64'(out_bytes),  64'(0));
        chk("rst_out_last",   64'(out_last),   64'(0));
        chk("rst_flush_busy", 64'(flush_busy), 64'(0));
        chk("rst_flush_done", 64'(flush_done), 64'(0));
        chk("rst_in_ready",   64'(in_ready),   64'(1));
        chk_stats("rst");

        // Eight aligned 32-byte beats: one word per beat, no stall
        for (int k = 0; k < 8; k++) push_exp(mk_word(32*k, 32), 32, 1'b0);
        total_w = 0;
        for (int k = 0; k < 8; k++) begin
            send_beat(mk_beat(32*k, 32), 32, w);
            total_w += w;
            if (k == 0) chk("t1_first_valid", 64'(out_valid), 64'(1));
        end
        chk("t1_no_stall", 64'(total_w), 64'(0));
        wait_drain("t1");

        // Eight 20-byte beats: five words of the continuous ramp
        for (int k = 0; k < 5; k++) push_exp(mk_word(32*k, 32), 32, 1'b0);
        for (int k = 0; k < 8; k++) send_beat(mk_beat(20*k, 20), 20, w);
        wait_drain("t2");
        chk("t2_cnt_zero", 64'(dut.r_cnt), 64'(0));

        // Masking: 3 bytes of 0xFF then 29 bytes of 0x00 with junk above len
        ew = '0;
        for (int i = 0; i < 3; i++) ew[i*8 +: 8] = 8'hFF;
        push_exp(ew, 32, 1'b0);
        send_beat({IN_BYTES{8'hFF}}, 3, w);
        d = '0;
        for (int i = 29; i < IN_BYTES; i++) d[i*8 +: 8] = 8'h5A;
        send_beat(d, 29, w);
        wait_drain("t3");
        chk("t3_cnt_zero", 64'(dut.r_cnt), 64'(0));

        // Length clamp: in_len 200 behaves as 34
        push_exp(mk_word(0, 32), 32, 1'b0);
        push_exp(mk_word(32, 32), 32, 1'b0);
        send_beat(mk_beat(0, 34), 200, w);
        send_beat(mk_beat(34, 30), 30, w);
        wait_drain("clamp");
        chk_stats("clamp");

        // Backpressure: one 34-byte beat fits, the next stalls until a pop
        push_exp(mk_word(100, 32), 32, 1'b0);
        push_exp(mk_word(132, 2) | (mk_word(150, 30) << 16), 32, 1'b0);
        push_exp(mk_word(180, 4), 4, 1'b1);
        out_ready = 1'b0;
        send_beat(mk_beat(100, 34), 34, w);
        in_valid = 1'b1;
        in_data  = mk_beat(150, 34);
        in_len   = LEN_WIDTH'(34);
        bad_rdy  = 0;
        bad_data = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (in_ready) bad_rdy++;
            if (!out_valid || out_data !== mk_word(100, 32)) bad_data++;
        end
        chk("t4_in_ready_low", 64'(bad_rdy), 64'(0));
        chk("t4_out_stable",   64'(bad_data), 64'(0));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("t4_ready_on_pop", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        exp_in_bytes += 34;
        chk("t4_cnt_36", 64'(dut.r_cnt), 64'(36));
        do_flush(imm, bad_rdy);
        chk("t4_flush_ready_low", 64'(bad_rdy), 64'(0));
        wait_drain("t4");

        // Flush of a 10-byte partial word, then a flush with nothing buffered
        push_exp(mk_word(200, 10), 10, 1'b1);
        send_beat(mk_beat(200, 10), 10, w);
        do_flush(imm, bad_rdy);
        chk("t5_flush_ready_low", 64'(bad_rdy), 64'(0));
        chk("t5_done_not_early",  64'(imm), 64'(0));
        wait_drain("t5");
        do_flush(imm, bad_rdy);
        chk("t5_empty_done_next", 64'(imm), 64'(1));
        chk("t5_back_to_run",     64'(in_ready), 64'(1));
        chk("t5_cnt_zero",        64'(dut.r_cnt), 64'(0));
        chk_stats("t5");

        // Reset with 40 bytes buffered discards them
        out_ready = 1'b0;
        send_beat(mk_beat(1, 20), 20, w);
        send_beat(mk_beat(21, 20), 20, w);
        chk("t6_cnt_40", 64'(dut.r_cnt), 64'(40));
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_in_bytes  = 0;
        exp_out_words = 0;
        chk("t6_out_valid", 64'(out_valid), 64'(0));
        chk("t6_cnt_zero",  64'(dut.r_cnt), 64'(0));
        chk_stats("t6");
        out_ready = 1'b1;
        push_exp(mk_word(50, 32), 32, 1'b0);
        send_beat(mk_beat(50, 32), 32, w);
        wait_drain("t6");
        @(posedge clk);
        #1;
        chk_stats("end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
